// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks: FSM state encoding,
// divisor floor and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int unsigned UART_MIN_CLKS_PER_BIT = 4;

    // Zero-extension of narrower words does not change the XOR reduction.
    function automatic logic parity_bit(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both stages
// reset to 1 so a reset never looks like a start bit.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime divisor, 5..9 data bits, 1/2 stop bits,
// framing error reporting; parity checking is built only with UART_RX_PARITY_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD > 1 || DIV_W < 3) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_err_q, par_err_d;
`endif

    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] half;
    logic             at_last;

    uart_sync u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_L),
        .din   (i_RX_Serial),
        .dout  (rx_s)
    );

    assign div_in  = (i_Clks_Per_Bit < DIV_W'(UART_MIN_CLKS_PER_BIT)) ?
                     DIV_W'(UART_MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;
    assign half    = (div_q - DIV_W'(1)) >> 1;
    assign at_last = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q + DIV_W'(1);
        idx_d       = idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        ferr_d      = ferr_q;
        dv_d        = 1'b0;
        byte_d      = byte_q;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        perr_d      = perr_q;
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_d     = 1'b0;
`endif
                div_d      = div_in;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == half) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_last) begin
                    cnt_d   = '0;
                    perr_d  = rx_s != parity_bit(16'(shift_q), PARITY_ODD != 0);
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (at_last) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_s;
                    // Every stop bit is sampled; the last one publishes the frame.
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        dv_d        = 1'b1;
                        byte_d      = shift_q;
                        frame_err_d = ferr_q | ~rx_s;
`ifdef UART_RX_PARITY_EN
                        par_err_d   = perr_q;
`endif
                        state_d     = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            div_q       <= DIV_W'(UART_MIN_CLKS_PER_BIT);
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            ferr_q      <= 1'b0;
            dv_q        <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            ferr_q      <= ferr_d;
            dv_q        <= dv_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            perr_q      <= perr_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = par_err_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and a 9-bit/2-stop instance.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpb8, cpb9;
    logic        rx8, rx9;
    logic        dv8, ferr8, perr8, busy8;
    logic [7:0]  byte8;
    logic        dv9, ferr9, perr9, busy9;
    logic [8:0]  byte9;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
        logic       busy;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q9[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16), .PARITY_ODD(0)) u_dut8 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Clks_Per_Bit(cpb8), .i_RX_Serial(rx8),
        .o_RX_DV(dv8), .o_RX_Byte(byte8), .o_Frame_Err(ferr8),
        .o_Parity_Err(perr8), .o_Busy(busy8)
    );

    uart_rx_cfg #(.DATA_BITS(9), .STOP_BITS(2), .DIV_W(16), .PARITY_ODD(0)) u_dut9 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Clks_Per_Bit(cpb9), .i_RX_Serial(rx9),
        .o_RX_DV(dv9), .o_RX_Byte(byte9), .o_Frame_Err(ferr9),
        .o_Parity_Err(perr9), .o_Busy(busy9)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input int b, input logic fe,
                         input logic pe, input logic bz);
        check({tag, "_byte"}, b, int'(e.data));
        check({tag, "_frame_err"}, int'(fe), int'(e.ferr));
        check({tag, "_parity_err"}, int'(pe), int'(e.perr));
        check({tag, "_busy_at_dv"}, int'(bz), int'(e.busy));
        check({tag, "_dv_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (dv8) begin
            if (q8.size() == 0) check("dut8_unexpected_dv", 1, 0);
            else score("dut8", q8.pop_front(), int'(byte8), ferr8, perr8, busy8);
        end
        if (dv9) begin
            if (q9.size() == 0) check("dut9_unexpected_dv", 1, 0);
            else score("dut9", q9.pop_front(), int'(byte9), ferr9, perr9, busy9);
        end
    end

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx8 = v; else rx9 = v;
    endtask

    // Called at a negedge: the next posedge is edge 0 of the frame.
    task automatic send(input int sel, input logic [8:0] data, input int d_eff,
                        input int d_prog, input logic [1:0] stops, input logic bad_par);
        exp_t e;
        int   nbits = (sel == 0) ? 8 : 9;
        int   nstop = (sel == 0) ? 1 : 2;
        logic par   = (^data) ^ bad_par;
        e.data = data;
        e.ferr = (nstop == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        e.perr = (P == 1) ? bad_par : 1'b0;
        e.busy = ~stops[nstop-1];
        e.cyc  = cyc + 1 + 3 + ((d_eff - 1) >> 1) + (nbits + P + nstop) * d_eff;
        if (sel == 0) begin cpb8 = 16'(d_prog); q8.push_back(e); end
        else begin cpb9 = 16'(d_prog); q9.push_back(e); end
        set_rx(sel, 1'b0);
        repeat (d_eff) @(negedge clk);
        // Divisor must stay frozen for the rest of the frame.
        if (sel == 0) cpb8 = 16'd40; else cpb9 = 16'd40;
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, data[i]);
            repeat (d_eff) @(negedge clk);
        end
        if (P == 1) begin
            set_rx(sel, par);
            repeat (d_eff) @(negedge clk);
        end
        for (int k = 0; k < nstop; k++) begin
            set_rx(sel, stops[k]);
            repeat (d_eff) @(negedge clk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dv8"}, int'(dv8), 0);
        check({tag, "_byte8"}, int'(byte8), 0);
        check({tag, "_ferr8"}, int'(ferr8), 0);
        check({tag, "_perr8"}, int'(perr8), 0);
        check({tag, "_busy8"}, int'(busy8), 0);
        check({tag, "_byte9"}, int'(byte9), 0);
        check({tag, "_busy9"}, int'(busy9), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx8 = 1'b1; rx9 = 1'b1; cpb8 = 16'd16; cpb9 = 16'd5;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 D=16 0xA5: DV one cycle after edge 154
        send(0, 9'h0A5, 16, 16, 2'b11, 1'b0);
        repeat (10) @(negedge clk);

        // false start: 3-cycle glitch
        rx8 = 1'b0;
        repeat (3) @(negedge clk);
        check("false_start_busy_high", int'(busy8), 1);
        rx8 = 1'b1;
        repeat (20) @(negedge clk);
        check("false_start_busy_clear", int'(busy8), 0);

        // frame error, stuck-low line, then clean frame
        send(0, 9'h03C, 16, 16, 2'b00, 1'b0);
        repeat (100) @(negedge clk);
        check("wait_high_busy", int'(busy8), 1);
        rx8 = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_high_exit_busy", int'(busy8), 0);
        send(0, 9'h011, 16, 16, 2'b11, 1'b0);

        // back-to-back frames, no idle gap
        send(0, 9'h05A, 16, 16, 2'b11, 1'b0);
        send(0, 9'h0C3, 16, 16, 2'b11, 1'b0);
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send(0, 9'h007, 16, 16, 2'b11, 1'b0);
        send(0, 9'h007, 16, 16, 2'b11, 1'b1);
        repeat (10) @(negedge clk);
`endif

        // 9 data bits, 2 stop bits, D=5
        send(1, 9'h1FF, 5, 5, 2'b11, 1'b0);
        send(1, 9'h0C3, 5, 5, 2'b10, 1'b0);
        send(1, 9'h100, 5, 5, 2'b11, 1'b0);
        repeat (10) @(negedge clk);

        // reset in the middle of data bit 4
        cpb8 = 16'd16;
        rx8 = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx8 = i[0];
            repeat (16) @(negedge clk);
        end
        rx8 = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", int'(busy8), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(0, 9'h096, 16, 16, 2'b11, 1'b0);
        repeat (5) @(negedge clk);

        // divisor below the floor behaves as 4
        send(0, 9'h06D, 4, 2, 2'b11, 1'b0);
        repeat (30) @(negedge clk);

        check("dut8_queue_drained", q8.size(), 0);
        check("dut9_queue_drained", q9.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
